// File: rtl/eth_pkg.sv
// Shared Ethernet constants for the RMII bridge: FSM states, framing byte counts, CRC-32 values.
package eth_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PREAMBLE = 3'd1;
  localparam logic [2:0] ST_DATA     = 3'd2;
  localparam logic [2:0] ST_FCS      = 3'd3;
  localparam logic [2:0] ST_IFG      = 3'd4;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam int unsigned PREAMBLE_BYTES    = 8;
  localparam int unsigned HDR_BYTES         = 14;
  localparam int unsigned PAYLOAD_BYTES     = 5;
  localparam int unsigned MIN_PAYLOAD_BYTES = 46;
  localparam int unsigned FIELD_BYTES       = HDR_BYTES + PAYLOAD_BYTES;
  localparam int unsigned FCS_BYTES         = 4;
  localparam int unsigned IFG_CYCLES        = 48;

  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  // Dibit i of a byte, LSB-first wire order.
  function automatic logic [1:0] pick_dibit(input logic [7:0] b, input logic [1:0] i);
    logic [1:0] d;
    case (i)
      2'd0:    d = b[1:0];
      2'd1:    d = b[3:2];
      2'd2:    d = b[5:4];
      default: d = b[7:6];
    endcase
    return d;
  endfunction

endpackage

// File: rtl/eth_crc32_dibit.sv
// Combinational reflected CRC-32 step for one RMII dibit (bit 0 consumed first).
module eth_crc32_dibit
  import eth_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [1:0]  din,
  output logic [31:0] crc_next_c
);

  always_comb begin
    crc_next_c = crc;
    for (int i = 0; i < 2; i++) begin
      crc_next_c = (crc_next_c >> 1) ^ ({32{crc_next_c[0] ^ din[i]}} & CRC_POLY);
    end
  end

endmodule

// File: rtl/eth_tx.sv
// RMII transmitter: one read-response word -> one Ethernet II frame, one dibit per clock.
// Build option ETH_TX_PAD_EN: zero-pad the payload to the 46-byte Ethernet minimum.
module eth_tx
  import eth_pkg::*;
#(
  parameter logic [47:0] FPGA_MAC  = 48'h69_69_5A_06_54_91,
  parameter logic [47:0] HOST_MAC  = 48'h00_E0_4C_68_1E_0C,
  parameter logic [15:0] ETHERTYPE = 16'h88_B5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] rdata_i,
  input  logic        rw_i,
  input  logic        valid_i,
  output logic        txen,
  output logic [1:0]  txd
);

`ifdef ETH_TX_PAD_EN
  localparam int unsigned DATA_BYTES = HDR_BYTES + MIN_PAYLOAD_BYTES;
`else
  localparam int unsigned DATA_BYTES = FIELD_BYTES;
`endif
  localparam int unsigned CNT_W    = 6;
  localparam int unsigned HDR_BITS = 8 * FIELD_BYTES;

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       dibit_cnt, dibit_nxt;
  logic [31:0]      crc, crc_nxt, crc_upd_c;
  logic [15:0]      data_q, data_nxt;
  logic             rw_q, rw_nxt;
  logic             txen_nxt;
  logic [1:0]       txd_nxt;

  logic [HDR_BITS-1:0] hdr;
  logic [7:0]          hdr_b [FIELD_BYTES];
  logic [7:0]          frame_byte, fcs_byte, pre_byte;
  logic [1:0]          data_dibit;
  logic                byte_end;

  // Fixed fields plus captured word, byte 0 = first on the wire; bytes past the end are pad.
  assign hdr = {HOST_MAC, FPGA_MAC, ETHERTYPE, 7'b0, rw_q, 16'h0000, data_q};
  for (genvar g = 0; g < FIELD_BYTES; g++) begin : g_hdr
    assign hdr_b[g] = hdr[HDR_BITS-1-8*g -: 8];
  end

  assign frame_byte = (cnt < CNT_W'(FIELD_BYTES)) ? hdr_b[cnt[4:0]] : 8'h00;
  assign pre_byte   = (cnt == CNT_W'(PREAMBLE_BYTES - 1)) ? SFD_BYTE : PREAMBLE_BYTE;
  assign data_dibit = pick_dibit(frame_byte, dibit_cnt);
  assign byte_end   = (dibit_cnt == 2'd3);

  // FCS is the complemented CRC, least significant byte first.
  always_comb begin
    case (cnt[1:0])
      2'd0:    fcs_byte = ~crc[7:0];
      2'd1:    fcs_byte = ~crc[15:8];
      2'd2:    fcs_byte = ~crc[23:16];
      default: fcs_byte = ~crc[31:24];
    endcase
  end

  eth_crc32_dibit u_crc (
    .crc        (crc),
    .din        (data_dibit),
    .crc_next_c (crc_upd_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      dibit_cnt <= '0;
      crc       <= CRC_INIT;
      data_q    <= '0;
      rw_q      <= 1'b0;
      txen      <= 1'b0;
      txd       <= 2'b00;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      dibit_cnt <= dibit_nxt;
      crc       <= crc_nxt;
      data_q    <= data_nxt;
      rw_q      <= rw_nxt;
      txen      <= txen_nxt;
      txd       <= txd_nxt;
    end
  end

  // Next state; TX pins register the dibit chosen by the current state/counters.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dibit_nxt = dibit_cnt;
    crc_nxt   = crc;
    data_nxt  = data_q;
    rw_nxt    = rw_q;
    txen_nxt  = 1'b0;
    txd_nxt   = 2'b00;
    case (state)
      ST_IDLE: begin
        if (valid_i) begin
          data_nxt  = rdata_i;
          rw_nxt    = rw_i;
          cnt_nxt   = '0;
          dibit_nxt = '0;
          crc_nxt   = CRC_INIT;
          state_nxt = ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: begin
        txen_nxt  = 1'b1;
        txd_nxt   = pick_dibit(pre_byte, dibit_cnt);
        dibit_nxt = dibit_cnt + 2'd1;
        if (byte_end) begin
          if (cnt == CNT_W'(PREAMBLE_BYTES - 1)) begin
            cnt_nxt   = '0;
            state_nxt = ST_DATA;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      ST_DATA: begin
        txen_nxt  = 1'b1;
        txd_nxt   = data_dibit;
        crc_nxt   = crc_upd_c;
        dibit_nxt = dibit_cnt + 2'd1;
        if (byte_end) begin
          if (cnt == CNT_W'(DATA_BYTES - 1)) begin
            cnt_nxt   = '0;
            state_nxt = ST_FCS;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      ST_FCS: begin
        txen_nxt  = 1'b1;
        txd_nxt   = pick_dibit(fcs_byte, dibit_cnt);
        dibit_nxt = dibit_cnt + 2'd1;
        if (byte_end) begin
          if (cnt == CNT_W'(FCS_BYTES - 1)) begin
            cnt_nxt   = '0;
            state_nxt = ST_IFG;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      ST_IFG: begin
        // Output register lags by one cycle, so IFG_CYCLES-1 states give IFG_CYCLES idle cycles.
        if (cnt == CNT_W'(IFG_CYCLES - 2)) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_eth_tx.sv
// Self-checking bench for eth_tx: byte-level frame model with bit-serial CRC-32 reference.
module tb_eth_tx;

  localparam logic [47:0] FPGA_MAC  = 48'h69_69_5A_06_54_91;
  localparam logic [47:0] HOST_MAC  = 48'h00_E0_4C_68_1E_0C;
  localparam logic [15:0] ETHERTYPE = 16'h88_B5;
`ifdef ETH_TX_PAD_EN
  localparam int FRAME_BYTES = 60;
`else
  localparam int FRAME_BYTES = 19;
`endif
  localparam int TXEN_CYCLES = 4 * (8 + FRAME_BYTES + 4);
  localparam int IFG         = 48;
  localparam logic [31:0] RESIDUE = 32'hC704_DD7B;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rw = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] rdata = 16'h0000;
  logic        txen;
  logic [1:0]  txd;

  int checks = 0;
  int failures = 0;
  int idle_bad = 0;
  logic [1:0] rx[$];
  logic [1:0] expd[$];
  logic [55:0] exp_payload;

  eth_tx #(.FPGA_MAC(FPGA_MAC), .HOST_MAC(HOST_MAC), .ETHERTYPE(ETHERTYPE)) dut (
    .clk(clk), .rst_n(rst_n), .rdata_i(rdata), .rw_i(rw), .valid_i(valid),
    .txen(txen), .txd(txd)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (rst_n && !txen && txd !== 2'b00) idle_bad++;

  function automatic logic [31:0] crc_raw(input logic [7:0] b[$]);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      for (int k = 0; k < 8; k++) begin
        if (c[0] ^ b[i][k]) c = (c >> 1) ^ 32'hEDB8_8320;
        else c = c >> 1;
      end
    end
    return c;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  function automatic void push_byte(input logic [7:0] b);
    for (int j = 0; j < 4; j++) expd.push_back(b[2*j +: 2]);
  endfunction

  function automatic void build_expected(input logic [15:0] d, input logic r);
    logic [7:0] fb[$];
    logic [31:0] fcs;
    for (int i = 0; i < 6; i++) fb.push_back(HOST_MAC[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) fb.push_back(FPGA_MAC[47-8*i -: 8]);
    fb.push_back(ETHERTYPE[15:8]);
    fb.push_back(ETHERTYPE[7:0]);
    fb.push_back({7'b0, r});
    fb.push_back(8'h00);
    fb.push_back(8'h00);
    fb.push_back(d[15:8]);
    fb.push_back(d[7:0]);
    while (fb.size() < FRAME_BYTES) fb.push_back(8'h00);
    fcs = ~crc_raw(fb);
    for (int k = 0; k < 4; k++) fb.push_back(fcs[8*k +: 8]);
    expd.delete();
    for (int i = 0; i < 7; i++) push_byte(8'h55);
    push_byte(8'hD5);
    foreach (fb[i]) push_byte(fb[i]);
    exp_payload = {ETHERTYPE, 7'b0, r, 16'h0000, d};
  endfunction

  function automatic int mismatches();
    int m = 0;
    if (rx.size() != expd.size()) m++;
    for (int i = 0; i < rx.size() && i < expd.size(); i++) if (rx[i] !== expd[i]) m++;
    return m;
  endfunction

  function automatic logic [7:0] rx_byte(input int p);
    return {rx[p+3], rx[p+2], rx[p+1], rx[p]};
  endfunction

  function automatic logic [31:0] rx_residue();
    logic [7:0] b[$];
    for (int p = 32; p + 3 < rx.size(); p += 4) b.push_back(rx_byte(p));
    return bitrev32(crc_raw(b));
  endfunction

  function automatic logic [55:0] rx_payload();
    logic [55:0] pl = '0;
    if (rx.size() >= 32 + 4 * 19)
      for (int i = 12; i < 19; i++) pl = {pl[47:0], rx_byte(32 + 4 * i)};
    return pl;
  endfunction

  task automatic start_frame(input logic [15:0] d, input logic r);
    @(negedge clk);
    rdata = d;
    rw    = r;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Waits for txen, then records dibits while txen is high (optionally pulsing valid / stopping early).
  task automatic capture(input int pulse_at, input int stop_at, output int lat);
    lat = 0;
    while (!txen && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    rx.delete();
    while (txen && rx.size() < 2000) begin
      if (rx.size() == stop_at) break;
      rx.push_back(txd);
      if (pulse_at >= 0) valid = (rx.size() == pulse_at);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (txen !== 1'b0 || txd !== 2'b00)
      $display("FAIL reset_outputs txen=%b txd=%b required 0/00", txen, txd);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (txen !== 1'b0) $display("FAIL idle_after_reset txen=%b required 0", txen);
    if (txen !== 1'b0) failures++;
    if (txen !== 1'b0 || txd !== 2'b00) failures += 0;
  endtask

  task automatic test_frames();
    logic [15:0] d_tab[7];
    logic        r_tab[7];
    int lat, m, pre_bad;
    logic [31:0] res;
    logic [55:0] pl;
    d_tab = '{16'h6970, 16'h0000, 16'hFFFF, 16'hA5A5, 16'h0, 16'h0, 16'h0};
    r_tab = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int t = 4; t < 7; t++) begin
      d_tab[t] = 16'($urandom);
      r_tab[t] = 1'($urandom);
    end
    for (int t = 0; t < 7; t++) begin
      build_expected(d_tab[t], r_tab[t]);
      start_frame(d_tab[t], r_tab[t]);
      capture(-1, -1, lat);
      checks++;
      if (lat != 1) begin failures++; $display("FAIL frame%0d_latency got=%0d required=1", t, lat); end
      checks++;
      if (rx.size() != TXEN_CYCLES) begin
        failures++; $display("FAIL frame%0d_txen_len got=%0d required=%0d", t, rx.size(), TXEN_CYCLES);
      end
      m = mismatches();
      checks++;
      if (m != 0) begin failures++; $display("FAIL frame%0d_dibits mismatched=%0d required=0", t, m); end
      res = rx_residue();
      checks++;
      if (res !== RESIDUE) begin failures++; $display("FAIL frame%0d_residue got=%h required=%h", t, res, RESIDUE); end
      pl = rx_payload();
      checks++;
      if (pl !== exp_payload) begin failures++; $display("FAIL frame%0d_payload got=%h required=%h", t, pl, exp_payload); end
      if (t == 0) begin
        pre_bad = 0;
        for (int i = 0; i < 32 && i < rx.size(); i++)
          if (rx[i] !== ((i == 31) ? 2'b11 : 2'b01)) pre_bad++;
        checks++;
        if (pre_bad != 0 || rx.size() < 32) begin
          failures++; $display("FAIL preamble_sfd bad_dibits=%0d required=0", pre_bad);
        end
      end
      repeat (IFG + 4) @(negedge clk);
    end
  endtask

  task automatic test_valid_ignored();
    int lat, m, highs;
    build_expected(16'h1234, 1'b0);
    start_frame(16'h1234, 1'b0);
    capture(100, -1, lat);
    m = mismatches();
    checks++;
    if (rx.size() != TXEN_CYCLES || m != 0) begin
      failures++; $display("FAIL midframe_valid len=%0d mismatched=%0d required=%0d/0", rx.size(), m, TXEN_CYCLES);
    end
    highs = 0;
    repeat (150) begin
      @(negedge clk);
      if (txen) highs++;
    end
    checks++;
    if (highs != 0) begin failures++; $display("FAIL no_second_frame txen_cycles=%0d required=0", highs); end
    build_expected(16'hBEEF, 1'b1);
    start_frame(16'hBEEF, 1'b1);
    capture(-1, -1, lat);
    m = mismatches();
    checks++;
    if (lat != 1 || m != 0) begin
      failures++; $display("FAIL after_ifg_frame latency=%0d mismatched=%0d required=1/0", lat, m);
    end
    repeat (IFG + 4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, m, gap, highs;
    build_expected(16'hC3A5, 1'b1);
    @(negedge clk);
    rdata = 16'hC3A5;
    rw    = 1'b1;
    valid = 1'b1;
    capture(-1, -1, lat);
    m = mismatches();
    checks++;
    if (lat != 2 || m != 0) begin
      failures++; $display("FAIL b2b_first latency=%0d mismatched=%0d required=2/0", lat, m);
    end
    gap = 0;
    while (!txen && gap < 200) begin
      gap++;
      @(negedge clk);
    end
    valid = 1'b0;
    checks++;
    if (gap != IFG) begin failures++; $display("FAIL b2b_ifg_gap got=%0d required=%0d", gap, IFG); end
    capture(-1, -1, lat);
    m = mismatches();
    checks++;
    if (lat != 0 || m != 0) begin
      failures++; $display("FAIL b2b_second latency=%0d mismatched=%0d required=0/0", lat, m);
    end
    highs = 0;
    repeat (150) begin
      @(negedge clk);
      if (txen) highs++;
    end
    checks++;
    if (highs != 0) begin failures++; $display("FAIL b2b_no_third txen_cycles=%0d required=0", highs); end
  endtask

  task automatic test_reset_mid();
    int lat, m, highs;
    build_expected(16'h5A5A, 1'b0);
    start_frame(16'h5A5A, 1'b0);
    capture(-1, 150, lat);
    rst_n = 1'b0;
    #1;
    checks++;
    if (txen !== 1'b0 || txd !== 2'b00) begin
      failures++; $display("FAIL async_reset txen=%b txd=%b required 0/00", txen, txd);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    highs = 0;
    repeat (20) begin
      @(negedge clk);
      if (txen) highs++;
    end
    checks++;
    if (highs != 0) begin failures++; $display("FAIL reset_abandon txen_cycles=%0d required=0", highs); end
    build_expected(16'h0F0F, 1'b1);
    start_frame(16'h0F0F, 1'b1);
    capture(-1, -1, lat);
    m = mismatches();
    checks++;
    if (lat != 1 || rx.size() != TXEN_CYCLES || m != 0) begin
      failures++; $display("FAIL post_reset_frame latency=%0d len=%0d mismatched=%0d required=1/%0d/0",
                           lat, rx.size(), m, TXEN_CYCLES);
    end
    repeat (IFG + 4) @(negedge clk);
  endtask

  task automatic test_idle_txd();
    checks++;
    if (idle_bad != 0) begin failures++; $display("FAIL idle_txd nonzero_cycles=%0d required=0", idle_bad); end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_valid_ignored();
    test_back_to_back();
    test_reset_mid();
    test_idle_txd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
